// File: rtl/riscv_types_pkg.sv
// Shared RISC-V core types.
// Holds the owner encoding for the instruction/data memory arbiter.
package riscv_types_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between the fetch and data ports.
// Data normally wins; a fetch that has waited STARVE_LIMIT data grants wins next.
module mem_arbiter
   import riscv_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wd,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_owner_e       owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             fetch_pri;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      fetch_pri = 1'b0;
      d_gnt     = 1'b0;
      i_gnt     = 1'b0;
      fetch_pri = i_req && (starve_cnt == LIMIT);
      // Grants are gated by rst_n so nothing reaches the RAM while in reset.
      d_gnt     = rst_n && d_req && !fetch_pri;
      i_gnt     = rst_n && i_req && !d_gnt;
   end

   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_be   = 4'b0000;
      mem_addr = i_addr;
      mem_wd   = d_wd;
      mem_en   = i_gnt || d_gnt;
      if (d_gnt) begin
         mem_we   = d_we;
         mem_be   = d_be;
         mem_addr = d_addr;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         if (i_gnt)      owner <= OWN_I;
         else if (d_gnt) owner <= OWN_D;
         else            owner <= OWN_NONE;

         if (i_gnt || !i_req)
            starve_cnt <= '0;
         else if (d_gnt && (starve_cnt != LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign i_rvalid = (owner == OWN_I);
   assign d_rvalid = (owner == OWN_D);
   assign i_rdata  = mem_rd;
   assign d_rdata  = mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table plus reset corner sequences.
// A small byte-enabled RAM model stands in for the single-port memory.
module tb_mem_arbiter;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_req = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic              i_gnt, i_rvalid;
   logic [31:0]       i_rdata;
   logic              d_req = 1'b0, d_we = 1'b0;
   logic [3:0]        d_be = '0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [31:0]       d_wd = '0;
   logic              d_gnt, d_rvalid;
   logic [31:0]       d_rdata;
   logic              mem_en, mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wd;
   logic [31:0]       mem_rd;

   mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wd(d_wd),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // RAM model: read-before-write, data valid one cycle after mem_en.
   logic [31:0] ram [0:255];
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rd <= ram[mem_addr[9:2]];
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end
   end

   typedef struct {
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req, d_we;
      logic [3:0]  d_be;
      logic [31:0] d_addr, d_wd;
      logic        e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_rchk;
      logic [31:0] e_rdata;
      logic        e_mem_we;
      logic [3:0]  e_mem_be;
      logic [31:0] e_mem_addr;
   } vec_t;

   vec_t vecs [24];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic ir, input logic [31:0] ia,
      input logic dr, input logic dw, input logic [3:0] dbe,
      input logic [31:0] da, input logic [31:0] dwd,
      input logic ig, input logic dg, input logic irv, input logic drv,
      input logic rchk, input logic [31:0] rd,
      input logic mwe, input logic [3:0] mbe, input logic [31:0] maddr);
      vec_t v;
      v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_be = dbe;
      v.d_addr = da; v.d_wd = dwd; v.e_i_gnt = ig; v.e_d_gnt = dg;
      v.e_i_rv = irv; v.e_d_rv = drv; v.e_rchk = rchk; v.e_rdata = rd;
      v.e_mem_we = mwe; v.e_mem_be = mbe; v.e_mem_addr = maddr;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      i_req = v.i_req; i_addr = v.i_addr; d_req = v.d_req; d_we = v.d_we;
      d_be = v.d_be; d_addr = v.d_addr; d_wd = v.d_wd;
   endtask

   task automatic check_row(input int n, input vec_t v);
      string s;
      s = $sformatf("row%0d", n);
      check({s, ".i_gnt"}, 32'(i_gnt), 32'(v.e_i_gnt));
      check({s, ".d_gnt"}, 32'(d_gnt), 32'(v.e_d_gnt));
      check({s, ".i_rvalid"}, 32'(i_rvalid), 32'(v.e_i_rv));
      check({s, ".d_rvalid"}, 32'(d_rvalid), 32'(v.e_d_rv));
      check({s, ".mem_en"}, 32'(mem_en), 32'(v.e_i_gnt | v.e_d_gnt));
      check({s, ".mem_we"}, 32'(mem_we), 32'(v.e_mem_we));
      if (v.e_i_gnt | v.e_d_gnt) check({s, ".mem_addr"}, mem_addr, v.e_mem_addr);
      if (v.e_mem_we) begin
         check({s, ".mem_be"}, 32'(mem_be), 32'(v.e_mem_be));
         check({s, ".mem_wd"}, mem_wd, v.d_wd);
      end
      if (v.e_rchk) check({s, ".rdata"}, v.e_i_rv ? i_rdata : d_rdata, v.e_rdata);
   endtask

   initial begin
      vec_t idle;
      logic dg, pg_i;

      for (int k = 0; k < 256; k++) ram[k] = 32'h0;
      ram['h100 >> 2] = 32'h00500093;
      ram['h200 >> 2] = 32'h12345678;
      ram['h300 >> 2] = 32'h11112222;
      ram[0] = 32'hA0; ram[1] = 32'hA1; ram[2] = 32'hA2;

      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[0]  = idle;
      vecs[1]  = mk(1, 'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h100);
      vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h00500093, 0, 0, 0);
      vecs[3]  = mk(1, 'h100, 1, 0, 'hF, 'h200, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'h200);
      vecs[4]  = mk(1, 'h100, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 'h12345678, 0, 0, 'h100);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h00500093, 0, 0, 0);
      vecs[6]  = mk(0, 0, 1, 1, 4'b0011, 'h300, 'hAABBCCDD, 0, 1, 0, 0, 0, 0, 1, 4'b0011, 'h300);
      vecs[7]  = mk(0, 0, 1, 0, 'hF, 'h300, 0, 0, 1, 0, 1, 0, 0, 0, 0, 'h300);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h1111CCDD, 0, 0, 0);
      vecs[9]  = mk(1, 'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h0);
      vecs[10] = mk(1, 'h4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 'hA0, 0, 0, 'h4);
      vecs[11] = mk(1, 'h8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 'hA1, 0, 0, 'h8);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hA2, 0, 0, 0);
      // Starvation run: expected grant pattern D,D,D,D,I,D,D,D,D,I.
      for (int k = 0; k < 10; k++) begin
         dg   = !(k == 4 || k == 9);
         pg_i = (k == 5);
         vecs[13 + k] = mk(1, 'h0, 1, 0, 'hF, 'h200, 0, !dg, dg,
                           (k != 0) && pg_i, (k != 0) && !pg_i, k != 0,
                           pg_i ? 32'hA0 : 32'h12345678, 0, 0, dg ? 32'h200 : 32'h0);
      end
      vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'hA0, 0, 0, 0);

      // Outputs held quiet during reset even with both requests high.
      i_req = 1; d_req = 1; d_we = 1; i_addr = 'h100; d_addr = 'h200;
      #2;
      check("rst.i_gnt", 32'(i_gnt), 0);
      check("rst.d_gnt", 32'(d_gnt), 0);
      check("rst.mem_en", 32'(mem_en), 0);
      check("rst.mem_we", 32'(mem_we), 0);
      check("rst.i_rvalid", 32'(i_rvalid), 0);
      check("rst.d_rvalid", 32'(d_rvalid), 0);
      @(negedge clk);
      drive(idle);
      rst_n = 1;

      for (int n = 0; n < 24; n++) begin
         @(negedge clk);
         drive(vecs[n]);
         #1;
         check_row(n, vecs[n]);
      end

      // Reset in the cycle after a data grant drops the pending response.
      @(negedge clk);
      drive(mk(0, 0, 1, 0, 'hF, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1 check("rst2.d_gnt_pre", 32'(d_gnt), 1);
      @(posedge clk);
      #1 rst_n = 0;
      #1;
      check("rst2.d_rvalid", 32'(d_rvalid), 0);
      check("rst2.i_rvalid", 32'(i_rvalid), 0);
      check("rst2.d_gnt", 32'(d_gnt), 0);
      check("rst2.mem_en", 32'(mem_en), 0);
      check("rst2.mem_we", 32'(mem_we), 0);
      @(negedge clk);
      rst_n = 1;
      drive(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      check("rst2.i_gnt_first", 32'(i_gnt), 1);
      check("rst2.d_rvalid_after", 32'(d_rvalid), 0);
      @(negedge clk);
      drive(idle);
      #1;
      check("rst2.i_rvalid", 32'(i_rvalid), 1);
      check("rst2.d_rvalid_late", 32'(d_rvalid), 0);
      check("rst2.i_rdata", i_rdata, 32'h00500093);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while fetch waits.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  32  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  data write (1) / read (0).
- d_be  in  4  write byte enables.
- d_addr  in  ADDR_W  data byte address.
- d_wd  in  32  write data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  data read data valid, or write acknowledge.
- d_rdata  out  32  load data.
- mem_en  out  1  single-port RAM access strobe.
- mem_we  out  1  RAM write.
- mem_be  out  4  RAM byte enables.
- mem_addr  out  ADDR_W  RAM address.
- mem_wd  out  32  RAM write data.
- mem_rd  in  32  RAM read data, valid one cycle after mem_en.

Function
REQ-004 SHALL share one synchronous single-port RAM between the fetch and data ports; at most one grant per cycle.
REQ-005 Grant SHALL be combinational: gnt high in the same cycle as the winning req; mem_* then driven from the winner's inputs.
REQ-006 Default priority SHALL be data over fetch.
REQ-007 Starvation counter SHALL increment on each d_gnt while i_req is high, and clear on i_gnt or when i_req is low.
REQ-008 When the counter equals STARVE_LIMIT and i_req is high, fetch SHALL win over data.
REQ-009 The counter SHALL saturate at STARVE_LIMIT.
REQ-010 A requester SHALL hold req and all request fields stable until gnt; deasserting req before gnt SHALL be legal and issue nothing.
REQ-011 The response SHALL arrive exactly one cycle after grant on the granted port's rvalid; rdata = mem_rd in that cycle.
REQ-012 A write SHALL produce d_rvalid one cycle after d_gnt; d_rdata is don't-care.
REQ-013 A new grant SHALL be allowed in the same cycle as a response, giving a sustained throughput of one access per cycle.
REQ-014 A registered owner state SHALL record the outstanding response target: OWN_NONE, OWN_I or OWN_D.
- grant to I: owner <= OWN_I.
- grant to D: owner <= OWN_D.
- no grant: owner <= OWN_NONE.
REQ-015 rvalid SHALL be a function of owner only; i_rvalid and d_rvalid SHALL never both be high.
REQ-016 With no req, mem_en SHALL be 0 and the other mem_* outputs are don't-care; mem_we SHALL be 0 whenever mem_en is 0.
REQ-017 i_gnt SHALL never drive mem_we high.

Reset
REQ-018 While rst_n is low:
- owner = OWN_NONE, starvation counter = 0.
- i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we = 0.
REQ-019 Reset asserted with a response outstanding SHALL drop that response; no rvalid after deassertion.
REQ-020 Grants SHALL be possible in the first clock edge after rst_n rises.

Structure
REQ-021 Enum arb_owner_e {OWN_NONE, OWN_I, OWN_D} SHALL live in the shared riscv types package.
REQ-022 The block SHALL be flat, with no sub-module.

Verification
REQ-023 i_req only, i_addr=0x100, mem_rd=0x00500093 -> i_gnt same cycle, i_rvalid next cycle, i_rdata=0x00500093.
REQ-024 i_req and d_req both high, d_we=0, d_addr=0x200 -> d_gnt, i_gnt=0; d_rvalid next cycle; i_gnt the cycle after if d_req drops.
REQ-025 d_req and i_req held for 10 cycles, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I,D,D,D,D,I.
REQ-026 Data write d_addr=0x300, d_be=4'b0011, d_wd=0xAABBCCDD -> mem_we=1, mem_be=4'b0011 in the grant cycle; d_rvalid next cycle; a later read of 0x300 returns the low half updated.
REQ-027 Back-to-back fetches 0x0, 0x4, 0x8 -> one grant per cycle; i_rvalid high for three consecutive cycles, data in order.
REQ-028 rst_n pulled low in the cycle after d_gnt -> d_rvalid stays 0, all outputs at reset values, normal grants resume after rst_n rises.
